// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for a shared DATA_W-bit bus with N_REQ requesters.
// Owns the bus mux select (one-hot grant plus encoded sel), bounds each
// ownership with MAX_HOLD cycles and inserts a one-cycle gap between owners.
module rr_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          done,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          grant,
  output logic [2:0]                sel,
  output logic                      bus_valid,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      busy
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_OWNED = 2'd1;
  localparam logic [1:0]  ST_GAP   = 2'd2;

  localparam int unsigned NR       = N_REQ;
  localparam logic [2:0]  LAST_RST = 3'(N_REQ - 1);
  localparam logic [7:0]  HOLD_LIM = 8'(MAX_HOLD);

  logic [1:0]        r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [2:0]        r_sel;
  logic [2:0]        r_last;
  logic [7:0]        r_hold;

  logic              w_any;
  logic [2:0]        w_win;
  logic [N_REQ-1:0]  w_win_oh;
  logic              w_release;
  logic              w_valid;
  logic [DATA_W-1:0] w_bus;

  // Winner: first asserted request scanning last_owner+1 .. last_owner (mod N_REQ)
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (!w_any && req[i] && (((32'(r_last) + k) % NR) == i)) begin
          w_any       = 1'b1;
          w_win       = 3'(i);
          w_win_oh[i] = 1'b1;
        end
      end
    end
  end

  // Owner gives up the bus on its own done, dropped request or hold expiry
  assign w_release = (|(done & r_grant)) || !(|(req & r_grant)) ||
                     ((MAX_HOLD != 0) && (r_hold == HOLD_LIM));

  // Arbitration state, grant/select registers and hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_last  <= LAST_RST;
      r_hold  <= '0;
    end else begin
      case (r_state)
        // IDLE and GAP arbitrate identically; grant is already zero in both
        ST_IDLE, ST_GAP: begin
          if (w_any) begin
            r_state <= ST_OWNED;
            r_grant <= w_win_oh;
            r_sel   <= w_win;
            r_last  <= w_win;
            r_hold  <= 8'd1;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        ST_OWNED: begin
          if (w_release) begin
            r_state <= ST_GAP;
            r_grant <= '0;
          end else if (r_hold != '1) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign w_valid = |r_grant;

  // Bus mux: slice chosen by sel, forced to zero when nobody owns the bus
  always_comb begin
    w_bus = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (w_valid && (r_sel == 3'(i))) begin
        w_bus = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant     = r_grant;
  assign sel       = r_sel;
  assign bus_valid = w_valid;
  assign bus_data  = w_bus;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  grant;
  logic [2:0]    sel;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit mdl_ok = 1'b0;

  // Model state: current owner (-1 when none), gap flag, owned-cycle count
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_cnt   = 0;
  int m_last  = N - 1;
  int m_sel   = 0;

  rr_bus_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .data_in(data_in),
    .grant(grant), .sel(sel), .bus_valid(bus_valid), .bus_data(bus_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_owner >= 0) ? data_in[m_sel*DW +: DW] : '0;
  endfunction

  // Reference model advances on every rising edge from the sampled inputs
  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_gap   <= 1'b0;
      m_cnt   <= 0;
      m_last  <= N - 1;
      m_sel   <= 0;
    end else if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner] || (MH != 0 && m_cnt == MH)) begin
        m_owner <= -1;
        m_gap   <= 1'b1;
      end else if (m_cnt < 255) begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_gap <= 1'b0;
      if (pick(req, m_last) >= 0) begin
        m_owner <= pick(req, m_last);
        m_last  <= pick(req, m_last);
        m_sel   <= pick(req, m_last);
        m_cnt   <= 1;
      end
    end
  end

  // Compare all outputs against the model mid-cycle
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("m_grant", 32'(grant), 32'(exp_grant()));
      chk("m_sel", 32'(sel), 32'(m_sel));
      chk("m_valid", 32'(bus_valid), 32'(m_owner >= 0));
      chk("m_data", 32'(bus_data), 32'(exp_data()));
      chk("m_busy", 32'(busy), 32'((m_owner >= 0) || m_gap));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = '0;
    step();
    step();
    rst  = 1'b0;
  endtask

  logic [N-1:0] e3 [11];
  logic [N-1:0] e4 [6];

  initial begin
    rst     = 1'b1;
    req     = '0;
    done    = '0;
    data_in = 32'h3C5A_96A5;
    e3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    e4 = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    step();
    mdl_ok = 1'b1;
    step();
    rst = 1'b0;
    look();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_data", 32'(bus_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single requester, done three cycles after grant
    step();
    req = 4'b0001;
    step();
    look();
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_data", 32'(bus_data), 32'hA5);
    step();
    step();
    done = 4'b0001;
    req  = 4'b0000;
    step();
    done = '0;
    look();
    chk("s1_gap_grant", 32'(grant), 32'h0);
    chk("s1_gap_data", 32'(bus_data), 32'h0);
    chk("s1_gap_busy", 32'(busy), 32'h1);
    step();
    look();
    chk("s1_idle_busy", 32'(busy), 32'h0);

    // All requesting, done each ownership: strict rotation with gaps
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      step();
      done = N'(1 << (j % N));
      look();
      chk("s2_grant", 32'(grant), 32'(1 << (j % N)));
      chk("s2_sel", 32'(sel), 32'(j % N));
      step();
      done = '0;
      look();
      chk("s2_gap", 32'(grant), 32'h0);
    end

    // Hold limit alternates two requesters
    do_reset();
    req = 4'b0011;
    for (int j = 0; j < 11; j++) begin
      step();
      look();
      chk("s3_grant", 32'(grant), 32'(e3[j]));
    end

    // Lone requester regranted after its gap, busy stays high
    do_reset();
    req = 4'b0100;
    for (int j = 0; j < 6; j++) begin
      step();
      look();
      chk("s4_grant", 32'(grant), 32'(e4[j]));
      chk("s4_busy", 32'(busy), 32'h1);
    end

    // Owner drops request; non-owner done is ignored
    step();
    req  = 4'b0001;
    done = 4'b0010;
    look();
    chk("s5_hold", 32'(grant), 32'h4);
    step();
    done = '0;
    look();
    chk("s5_gap", 32'(grant), 32'h0);
    chk("s5_gap_busy", 32'(busy), 32'h1);
    step();
    look();
    chk("s5_next", 32'(grant), 32'h1);
    chk("s5_sel", 32'(sel), 32'h0);

    // Reset during ownership of requester 3
    do_reset();
    req = 4'b1000;
    step();
    look();
    chk("s6_own", 32'(grant), 32'h8);
    chk("s6_sel", 32'(sel), 32'h3);
    step();
    rst = 1'b1;
    req = 4'b1111;
    step();
    rst = 1'b0;
    look();
    chk("s6_rst_grant", 32'(grant), 32'h0);
    chk("s6_rst_valid", 32'(bus_valid), 32'h0);
    chk("s6_rst_busy", 32'(busy), 32'h0);
    step();
    look();
    chk("s6_first", 32'(grant), 32'h1);

    // Randomized traffic checked by the model
    for (int n = 0; n < 2000; n++) begin
      step();
      data_in = 32'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = !req[b];
      end
      done = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
    end
    step();
    look();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit output bus between N_REQ requesters.
- Owns the select of the bus mux (an N_REQ-to-1 mux per bit): one-hot grants plus an encoded select.
- Bounds ownership with a hold limit and inserts a one-cycle turnaround gap between owners.
- Sits between the requesting engines and the shared datapath bus.

Parameters:
- N_REQ, 4, number of requesters; legal values 2..8.
- DATA_W, 8, width of each requester's data and of the shared bus.
- MAX_HOLD, 16, maximum owned cycles per grant; 0 = unlimited; legal values 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per requester; level, held until done.
- done  input  N_REQ  end-of-transfer pulse from the owner; ignored from non-owners.
- data_in  input  N_REQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot grant, registered.
- sel  output  3  encoded index of the current owner, registered; upper unused bits 0.
- bus_valid  output  1  high exactly when grant is nonzero.
- bus_data  output  DATA_W  data_in slice selected by sel when bus_valid, else 0; combinational from registered sel/grant.
- busy  output  1  high in OWNED and GAP.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: grant=0, sel=0, bus_valid=0, bus_data=0, busy=0, state=IDLE, hold counter=0, last_owner=N_REQ-1 (so requester 0 has top priority).
- States: IDLE, OWNED, GAP.
- Winner selection: first asserted req scanning last_owner+1, last_owner+2, … modulo N_REQ. last_owner itself is checked last.
- IDLE:
  - If any req is high at edge t, go to OWNED at t+1 with grant/sel set to the winner.
  - On entry, last_owner takes the winner and the hold counter loads 1.
  - Request-to-grant latency is one cycle.
- OWNED: leave to GAP at the next edge when any of these holds:
  - done[owner]=1,
  - req[owner]=0,
  - MAX_HOLD!=0 and hold counter==MAX_HOLD.
  - Otherwise stay and increment the counter; it saturates, with no wrap when MAX_HOLD=0.
  - An owner therefore holds at most MAX_HOLD cycles.
- GAP:
  - Lasts exactly one cycle; grant=0, bus_valid=0, busy=1.
  - Arbitration uses req sampled in the GAP cycle.
  - If any req is high, go directly to OWNED with the new winner; else go to IDLE.
  - A preempted owner that still requests competes normally; it wins only if no other requester is asserted.
- Simultaneous events:
  - done and hold expiry in the same cycle count as one release.
  - done from a non-owner has no effect.
  - A new req arriving during OWNED waits; it never preempts.
- grant is always zero or one-hot. sel holds its last value while grant=0, but bus_data is forced to 0.
- rst mid-transfer: the state returns to reset values at that edge with no GAP; arbitration resumes from priority 0.
- Requests beyond N_REQ do not exist; sel never exceeds N_REQ-1.

Test Plan:
- Reset then req=4'b0001 held, data_in[7:0]=8'hA5, done pulsed 3 cycles after grant -> grant=0001 one cycle after req, bus_data=A5 while owned, one GAP cycle with bus_data=0, then IDLE.
- req=4'b1111 held, done pulsed each ownership -> grant order 0001,0010,0100,1000,0001 with one zero-grant GAP between each; sel sequence 0,1,2,3,0.
- MAX_HOLD=4, req=4'b0011 held, no done -> requester 0 owned exactly 4 cycles, GAP, requester 1 owned 4 cycles, GAP, requester 0 again.
- MAX_HOLD=4, req=4'b0100 only, never done -> grant 0100 for 4 cycles, GAP, regranted 0100; busy never drops.
- Requester 2 owns, then req[2] drops while req[0] rises and done[1] pulses (non-owner) -> release to GAP on req[2] drop, done[1] ignored, next grant 0001.
- rst asserted while requester 3 owns -> next cycle grant=0, bus_valid=0, busy=0, state IDLE; with req=1111 still held, the first grant after rst deasserts is 0001.
